// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and its datapath (slave).
interface multicycle_controller_if;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCEn;
    logic       RegDst;
    logic       Mem2Reg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  OP, Funct, Zero, MemReady,
        output MemRead, MemWrite, IorD, IRWrite, PCEn, RegDst, Mem2Reg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, Illegal, State
    );

    modport slave (
        output OP, Funct, Zero, MemReady,
        input  MemRead, MemWrite, IorD, IRWrite, PCEn, RegDst, Mem2Reg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with MemReady-qualified strobes.
// Optional jump support is enabled by defining MCC_JUMP_EN.
module multicycle_controller (
    input  logic                    CLK,
    input  logic                    RST,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    // State-only part of the output decode; the *_on_* flags mark strobes that
    // must still be qualified by a same-cycle input.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem2reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       pc_ir_on_ready;
        logic       pc_on_zero;
        logic       pc_always;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MCC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read       = 1'b1;
                c.alu_src_b      = 2'b01;
                c.alu_control    = 3'b010;
                c.pc_ir_on_ready = 1'b1;
            end
            DECODE: begin
                c.alu_src_b   = 2'b11;
                c.alu_control = 3'b010;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'b10;
                c.alu_control = 3'b010;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write = 1'b1;
                c.mem2reg   = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = funct_alu(f);
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
                c.pc_on_zero  = 1'b1;
            end
            ADDIWB: c.reg_write = 1'b1;
`ifdef MCC_JUMP_EN
            JUMP: begin
                c.pc_src    = 2'b10;
                c.pc_always = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_q;
    logic   op_legal;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = FETCH;
        op_legal   = 1'b1;
        case (state)
            FETCH:  state_next = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.OP)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(bus.Funct)) state_next = EXEC;
                        else                        op_legal   = 1'b0;
                    end
                    OP_BEQ:  state_next = BRANCH;
                    OP_ADDI: state_next = ADDIEX;
`ifdef MCC_JUMP_EN
                    OP_J:    state_next = JUMP;
`endif
                    default: op_legal = 1'b0;
                endcase
            end
            MEMADR: state_next = (bus.OP == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_next = bus.MemReady ? MEMWB : MEMRD;
            MEMWR:  state_next = bus.MemReady ? FETCH : MEMWR;
            EXEC:   state_next = ALUWB;
            ADDIEX: state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the synchronous reset
    // loads the FETCH decode so the first cycle out of reset already drives FETCH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= FETCH;
            ctrl_q <= state_ctrl(FETCH, 6'd0);
        end else begin
            state  <= state_next;
            ctrl_q <= state_ctrl(state_next, bus.Funct);
        end
    end

    assign bus.MemRead    = ctrl_q.mem_read;
    assign bus.MemWrite   = ctrl_q.mem_write & ~RST;
    assign bus.IorD       = ctrl_q.iord;
    assign bus.IRWrite    = ctrl_q.pc_ir_on_ready & bus.MemReady & ~RST;
    assign bus.PCEn       = ~RST & (ctrl_q.pc_always
                                    | (ctrl_q.pc_ir_on_ready & bus.MemReady)
                                    | (ctrl_q.pc_on_zero & bus.Zero));
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.Mem2Reg    = ctrl_q.mem2reg;
    assign bus.RegWrite   = ctrl_q.reg_write & ~RST;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.PCSrc      = ctrl_q.pc_src;
    assign bus.ALUControl = ctrl_q.alu_control;
    // Decode fault is a one-cycle pulse raised while the faulty opcode sits in DECODE.
    assign bus.Illegal    = ~RST & (state == DECODE) & ~op_legal;
    assign bus.State      = state;

endmodule
